// File: rtl/uart_rx_frame_deframer.sv
// UART receiver with idle-timeout framing: recovers characters from rx_i, flags sof/eof.
// Latency: rx_valid one cycle after the final stop sample; rx_eof IDLE_BITS bit-times after it.
// Backpressure: none; the receiver free-runs and every character is strobed out exactly once.
module uart_rx_frame_deframer #(
    parameter int DATA_BIT  = 8,
    parameter int IDLE_BITS = 4
) (
    input  logic                sys_clk_i,
    input  logic                rst_n_i,
    input  logic [15:0]         baud_cnt_max,
    input  logic [1:0]          uart_parity_bit,
    input  logic [1:0]          uart_stop_bit,
    input  logic                rx_i,
    output logic [DATA_BIT-1:0] rx_data,
    output logic                rx_valid,
    output logic                rx_sof,
    output logic                rx_parity_err,
    output logic                rx_frame_err,
    output logic                rx_eof
);

    localparam int BIW = (DATA_BIT > 1) ? $clog2(DATA_BIT) : 1;
    localparam int ICW = $clog2(IDLE_BITS + 1);
    localparam logic [BIW-1:0] BIT_LAST  = BIW'(DATA_BIT - 1);
    localparam logic [ICW-1:0] IDLE_LAST = ICW'(IDLE_BITS - 1);
    localparam logic [ICW-1:0] IDLE_FULL = ICW'(IDLE_BITS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP1,
        ST_STOP2
    } state_t;

    // synchronizer and edge-detect history, all idling high
    logic rx_meta_q, rx_s_q, rx_prev_q;
    logic rx_fall;

    state_t              state_q, state_d;
    logic [15:0]         bc_q, bc_d;
    logic [15:0]         n_q, n_d;
    logic [1:0]          par_q, par_d;
    logic [1:0]          stop_q, stop_d;
    logic [BIW-1:0]      bit_idx_q, bit_idx_d;
    logic [DATA_BIT-1:0] shreg_q, shreg_d;
    logic                perr_q, perr_d;
    logic                ferr_q, ferr_d;
    logic                frame_open_q, frame_open_d;
    logic [ICW-1:0]      idle_cnt_q, idle_cnt_d;

    logic [DATA_BIT-1:0] rx_data_q, rx_data_d;
    logic                rx_valid_q, rx_valid_d;
    logic                rx_sof_q, rx_sof_d;
    logic                rx_perr_q, rx_perr_d;
    logic                rx_ferr_q, rx_ferr_d;
    logic                rx_eof_q, rx_eof_d;

    logic bc_last;
    logic par_en;
    logic par_x;
    logic deliver;
    logic ferr_now;

    assign rx_fall = rx_prev_q & ~rx_s_q;

    // 2-FF synchronizer plus one history flop for falling-edge detection
    always_ff @(posedge sys_clk_i) begin
        if (!rst_n_i) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    // next-state logic: bit timing, character assembly and idle-timeout framing
    always_comb begin
        state_d      = state_q;
        bc_d         = bc_q;
        n_d          = n_q;
        par_d        = par_q;
        stop_d       = stop_q;
        bit_idx_d    = bit_idx_q;
        shreg_d      = shreg_q;
        perr_d       = perr_q;
        ferr_d       = ferr_q;
        frame_open_d = frame_open_q;
        idle_cnt_d   = idle_cnt_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        rx_sof_d     = 1'b0;
        rx_perr_d    = 1'b0;
        rx_ferr_d    = 1'b0;
        rx_eof_d     = 1'b0;
        deliver      = 1'b0;
        ferr_now     = ferr_q;
        bc_last      = (bc_q == (n_q - 16'd1));
        par_en       = (par_q == 2'd1) || (par_q == 2'd2);
        par_x        = (^shreg_q) ^ rx_s_q;

        case (state_q)
            ST_IDLE: begin
                // a zero baud setting parks the receiver, including the idle timer
                if (baud_cnt_max != 16'd0) begin
                    if (frame_open_q && (idle_cnt_q != IDLE_FULL)) begin
                        if (bc_last) begin
                            bc_d       = 16'd0;
                            idle_cnt_d = idle_cnt_q + ICW'(1);
                            if (idle_cnt_q == IDLE_LAST) begin
                                rx_eof_d     = 1'b1;
                                frame_open_d = 1'b0;
                            end
                        end else begin
                            bc_d = bc_q + 16'd1;
                        end
                    end
                    // a start edge still clears the idle count; eof above wins if it fires now
                    if (rx_fall) begin
                        state_d    = ST_START;
                        bc_d       = 16'd0;
                        idle_cnt_d = '0;
                        n_d        = baud_cnt_max;
                        par_d      = uart_parity_bit;
                        stop_d     = uart_stop_bit;
                        bit_idx_d  = '0;
                        perr_d     = 1'b0;
                        ferr_d     = 1'b0;
                    end
                end
            end
            ST_START: begin
                if (bc_q == (n_q >> 1)) begin
                    bc_d = 16'd0;
                    // line back high at mid-start: glitch, drop it silently
                    state_d = rx_s_q ? ST_IDLE : ST_DATA;
                end else begin
                    bc_d = bc_q + 16'd1;
                end
            end
            ST_DATA: begin
                if (bc_last) begin
                    bc_d    = 16'd0;
                    shreg_d = {rx_s_q, shreg_q[DATA_BIT-1:1]};
                    if (bit_idx_q == BIT_LAST) begin
                        state_d = par_en ? ST_PARITY : ST_STOP1;
                    end else begin
                        bit_idx_d = bit_idx_q + BIW'(1);
                    end
                end else begin
                    bc_d = bc_q + 16'd1;
                end
            end
            ST_PARITY: begin
                if (bc_last) begin
                    bc_d    = 16'd0;
                    // odd wants an overall XOR of 1, even wants 0
                    perr_d  = (par_q == 2'd1) ? ~par_x : par_x;
                    state_d = ST_STOP1;
                end else begin
                    bc_d = bc_q + 16'd1;
                end
            end
            ST_STOP1: begin
                if (bc_last) begin
                    bc_d     = 16'd0;
                    ferr_now = ferr_q | ~rx_s_q;
                    // 1.5 stop bits are received as a single stop bit
                    if (stop_q == 2'd2) begin
                        ferr_d  = ferr_now;
                        state_d = ST_STOP2;
                    end else begin
                        deliver = 1'b1;
                    end
                end else begin
                    bc_d = bc_q + 16'd1;
                end
            end
            ST_STOP2: begin
                if (bc_last) begin
                    bc_d     = 16'd0;
                    ferr_now = ferr_q | ~rx_s_q;
                    deliver  = 1'b1;
                end else begin
                    bc_d = bc_q + 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                bc_d    = 16'd0;
            end
        endcase

        // character complete: present it and restart the idle timer from here
        if (deliver) begin
            state_d      = ST_IDLE;
            rx_valid_d   = 1'b1;
            rx_data_d    = shreg_q;
            rx_perr_d    = perr_q;
            rx_ferr_d    = ferr_now;
            rx_sof_d     = ~frame_open_q;
            frame_open_d = 1'b1;
            idle_cnt_d   = '0;
            bc_d         = 16'd0;
        end
    end

    // state and output registers
    always_ff @(posedge sys_clk_i) begin
        if (!rst_n_i) begin
            state_q      <= ST_IDLE;
            bc_q         <= 16'd0;
            n_q          <= 16'd0;
            par_q        <= 2'd0;
            stop_q       <= 2'd0;
            bit_idx_q    <= '0;
            shreg_q      <= '0;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
            frame_open_q <= 1'b0;
            idle_cnt_q   <= '0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            rx_sof_q     <= 1'b0;
            rx_perr_q    <= 1'b0;
            rx_ferr_q    <= 1'b0;
            rx_eof_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            bc_q         <= bc_d;
            n_q          <= n_d;
            par_q        <= par_d;
            stop_q       <= stop_d;
            bit_idx_q    <= bit_idx_d;
            shreg_q      <= shreg_d;
            perr_q       <= perr_d;
            ferr_q       <= ferr_d;
            frame_open_q <= frame_open_d;
            idle_cnt_q   <= idle_cnt_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            rx_sof_q     <= rx_sof_d;
            rx_perr_q    <= rx_perr_d;
            rx_ferr_q    <= rx_ferr_d;
            rx_eof_q     <= rx_eof_d;
        end
    end

    assign rx_data       = rx_data_q;
    assign rx_valid      = rx_valid_q;
    assign rx_sof        = rx_sof_q;
    assign rx_parity_err = rx_perr_q;
    assign rx_frame_err  = rx_ferr_q;
    assign rx_eof        = rx_eof_q;

endmodule
